// File: rtl/seq_div8.sv
// rtl/seq_div8.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                request, accepted only while busy==0
//   dividend, divisor    operands, sampled on the accepted start
//   busy                 high while the iteration loop is running
//   done                 one-cycle pulse; results valid from this cycle on
//   quotient, remainder  floor(dividend/divisor), dividend mod divisor
//   div_by_zero          set together with done when divisor==0
module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;        // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // One iteration: shift {R,Q} left, trial-subtract the divisor from R.
  // The difference is one bit wider than R so its MSB is the borrow.
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    r_sh   = {r_q, q_q[WIDTH-1]};
    diff   = r_sh + {2'b11, ~div_q} + {{(WIDTH+1){1'b0}}, 1'b1};
    borrow = diff[WIDTH+1];
    r_next = borrow ? r_sh[WIDTH:0] : diff[WIDTH:0];
    q_next = {q_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        // A start in the DONE cycle is accepted since busy is already low.
        if (start) begin
          div_d = divisor;
          r_d   = '0;
          q_d   = dividend;
          cnt_d = CW'(WIDTH - 1);
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_next;
          rem_d   = r_next[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div8.sv
// tb/tb_seq_div8.sv - scoreboard bench for seq_div8 against an arithmetic reference
module tb_seq_div8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  seq_div8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int z;
    int due;
    int a;
    int b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_q = 0, last_r = 0, last_z = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on every done pulse, otherwise checks outputs hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_q = 0; last_r = 0; last_z = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("quotient %0d/%0d", e.a, e.b), int'(quotient), e.q);
        check($sformatf("remainder %0d/%0d", e.a, e.b), int'(remainder), e.r);
        check($sformatf("div_by_zero %0d/%0d", e.a, e.b), int'(div_by_zero), e.z);
        check($sformatf("latency %0d/%0d", e.a, e.b), cyc, e.due);
        check("busy_in_done", int'(busy), 0);
        last_q = e.q; last_r = e.r; last_z = e.z;
      end
    end else begin
      check("hold_quotient", int'(quotient), last_q);
      check("hold_remainder", int'(remainder), last_r);
      check("hold_div_by_zero", int'(div_by_zero), last_z);
    end
  end

  // Called and returns at a negedge; acc is the posedge that samples the start.
  task automatic do_div(input int a, input int b, output int acc);
    int   guard = 0;
    exp_t e;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("busy_timeout", 1, 0);
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 8'(b);
    acc      = cyc + 1;
    e.a = a; e.b = b;
    if (b == 0) begin
      e.q = 255; e.r = a; e.z = 1; e.due = acc;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 0; e.due = acc + 8;
    end
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  function automatic int pick();
    int s;
    s = int'($urandom_range(0, 9));
    if (s == 0) return 0;
    if (s == 1) return 255;
    if (s == 2) return 1;
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    int acc;
    int guard;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(200, 7, acc);
    do_div(255, 1, acc);
    do_div(0, 13, acc);
    do_div(5, 9, acc);
    do_div(255, 255, acc);
    do_div(100, 0, acc);

    // Start pulse during RUN must be ignored; 17/5 then goes in the DONE cycle.
    do_div(200, 7, acc);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    do_div(17, 5, acc);

    // Reset in the 4th RUN cycle aborts the operation with no done pulse.
    do_div(50, 3, acc);
    while (cyc < acc + 3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_done", int'(done), 0);
    check("midrun_reset_quotient", int'(quotient), 0);
    check("midrun_reset_remainder", int'(remainder), 0);
    check("midrun_reset_div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_div(81, 9, acc);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
      do_div(pick(), pick(), acc);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
